// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 serial receiver with a byte FIFO,
// a ready/valid read port and sticky framing/overflow flags.
module uart_rx_buffered #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic [7:0] data_out,
  output logic data_out_valid,
  input  logic data_out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic frame_error,
  output logic overflow,
  input  logic err_clear
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME = SYMBOL_EDGE_TIME / 2;
  localparam int CW = $clog2(SYMBOL_EDGE_TIME);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] SAMPLE_LAST =
    CW'(SAMPLE_TIME - 1);
  localparam logic [CW-1:0] SYMBOL_LAST =
    CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic rx_m;
  logic rx_s;

  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [NW-1:0] count;

  logic stop_hit;
  logic byte_good;
  logic byte_bad;
  logic do_pop;
  logic do_push;
  logic drop;

  // Two-flop synchroniser; idles high so reset looks like a quiet line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= serial_in;
      rx_s <= rx_m;
    end
  end

  // Frame FSM: mid-bit sampling, LSB-first shift
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == SAMPLE_LAST) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == SYMBOL_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == SYMBOL_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The stop-bit sample drives the FIFO write in the same edge
  assign stop_hit  = (state == STOP) && (cnt == SYMBOL_LAST);
  assign byte_good = stop_hit && rx_s;
  assign byte_bad  = stop_hit && !rx_s;

  assign data_out_valid = (count != '0);
  assign do_pop  = data_out_valid && data_out_ready;
  assign do_push = byte_good && ((count != FULL) || do_pop);
  assign drop    = byte_good && !do_push;

  assign data_out   = mem[rd_ptr];
  assign fifo_count = count;

  // Circular buffer; pointers wrap on the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky status flags; a new event beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (byte_bad) begin
        frame_error <= 1'b1;
      end else if (err_clear) begin
        frame_error <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (err_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: drives 8N1 frames and checks the receiver
// every cycle against a queue-based model of the byte stream.
module tb_uart_rx_buffered;

  localparam int CF  = 50_000_000;
  localparam int BR  = 1_000_000;
  localparam int D   = 8;
  localparam int SET = CF / BR;
  localparam int HALF = SET / 2;
  // edges from the first start-bit drive to the stop-bit sample:
  // 2 sync + 1 detect + half a bit + 9 whole bits
  localparam int LAT = 3 + HALF + 9 * SET;
  localparam logic [14:0] M_ALL  = 15'h7fff;
  localparam logic [14:0] M_NODT = 15'h7f00;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic [7:0] data_out;
  logic data_out_valid;
  logic data_out_ready;
  logic [3:0] fifo_count;
  logic frame_error;
  logic overflow;
  logic err_clear;

  uart_rx_buffered #(
    .CLOCK_FREQ(CF),
    .BAUD_RATE(BR),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .fifo_count(fifo_count),
    .frame_error(frame_error),
    .overflow(overflow),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  logic [7:0] mq[$];
  bit mfe = 0;
  bit mov = 0;
  int cyc = 0;
  int last_rst = -1;

  int ev_cyc = -1;
  int ev_sched = -2;
  logic [7:0] ev_byte = 8'h00;
  bit ev_good = 1'b0;

  bit chk_en = 0;
  bit lit_pend = 0;
  string lit_name = "";
  logic [14:0] lit_exp = '0;
  logic [14:0] lit_mask = '0;

  int n_tests = 0;
  int n_fail = 0;

  function automatic logic [14:0] pk(bit v, int c, bit fe,
                                     bit ov, logic [7:0] d);
    return {v, c[3:0], fe, ov, d};
  endfunction

  // model: the byte stream as a queue, flags as plain bits
  initial forever begin
    bit pop;
    bit hit;
    bit keep;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      mfe = 0;
      mov = 0;
      last_rst = cyc;
    end else begin
      pop  = (mq.size() != 0) && data_out_ready;
      hit  = (ev_cyc == cyc) && (ev_sched > last_rst);
      keep = hit && ev_good && (mq.size() < D || pop);
      if (pop) void'(mq.pop_front());
      if (keep) mq.push_back(ev_byte);
      if (err_clear) begin
        mfe = 0;
        mov = 0;
      end
      if (hit && !ev_good) mfe = 1;
      if (hit && ev_good && !keep) mov = 1;
    end
  end

  // compare: every cycle against the model, plus literal pins
  initial forever begin
    logic [14:0] act;
    logic [14:0] exp;
    @(negedge clk);
    act = {data_out_valid, fifo_count, frame_error, overflow,
           data_out_valid ? data_out : 8'h00};
    if (chk_en) begin
      exp = pk(mq.size() != 0, mq.size(), mfe, mov,
               (mq.size() != 0) ? mq[0] : 8'h00);
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model cyc=%0d act=%h exp=%h",
                 cyc, act, exp);
      end
    end
    if (lit_pend) begin
      n_tests++;
      if ((act & lit_mask) !== (lit_exp & lit_mask)) begin
        n_fail++;
        $display("FAIL %s act=%h exp=%h mask=%h",
                 lit_name, act, lit_exp, lit_mask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic lit(string nm, logic [14:0] e, logic [14:0] m);
    lit_name = nm;
    lit_exp  = e;
    lit_mask = m;
    lit_pend = 1;
    tick();
    lit_pend = 0;
  endtask

  task automatic pop1();
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
  endtask

  task automatic clr();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  // rmode 0: ready low, 1: random ready/clear, 2: pop on push edge
  task automatic send(logic [7:0] b, bit stop_ok, int rmode,
                      int rst_at);
    ev_byte  = b;
    ev_good  = stop_ok;
    ev_sched = cyc;
    ev_cyc   = cyc + LAT;
    for (int i = 0; i < 10 * SET; i++) begin
      int k;
      k = i / SET;
      if (k == 0) serial_in = 1'b0;
      else if (k == 9) serial_in = stop_ok;
      else serial_in = b[k-1];
      if (rmode == 1) begin
        data_out_ready = ($urandom_range(3) == 0);
        err_clear = ($urandom_range(15) == 0);
      end else begin
        data_out_ready = (rmode == 2) && (i == LAT - 1);
        err_clear = 1'b0;
      end
      rst = (rst_at >= 0) && (i == rst_at || i == rst_at + 1);
      tick();
    end
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    err_clear = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    err_clear = 1'b0;
    idle(3);
    rst = 1'b0;
    chk_en = 1;
    lit("reset", pk(0, 0, 0, 0, 8'h00), M_ALL);

    send(8'hA5, 1, 0, -1);
    idle(20);
    lit("single", pk(1, 1, 0, 0, 8'hA5), M_ALL);
    pop1();
    lit("single_pop", pk(0, 0, 0, 0, 8'h00), M_NODT);

    for (int j = 0; j < 9; j++) begin
      send(8'(j), 1, 0, -1);
      idle(20);
    end
    lit("ovf_full", pk(1, 8, 0, 1, 8'h00), M_ALL);
    for (int j = 0; j < 8; j++) begin
      lit("ovf_order", pk(1, 8 - j, 0, 1, 8'(j)), M_ALL);
      pop1();
    end
    lit("ovf_empty", pk(0, 0, 0, 1, 8'h00), M_NODT);
    clr();
    lit("ovf_clr", pk(0, 0, 0, 0, 8'h00), M_NODT);

    send(8'h3C, 0, 0, -1);
    idle(20);
    lit("ferr", pk(0, 0, 1, 0, 8'h00), M_NODT);
    send(8'h5A, 1, 0, -1);
    idle(20);
    lit("after_ferr", pk(1, 1, 1, 0, 8'h5A), M_ALL);
    pop1();
    clr();

    serial_in = 1'b0;
    idle(10);
    serial_in = 1'b1;
    idle(60);
    lit("glitch", pk(0, 0, 0, 0, 8'h00), M_NODT);

    send(8'h11, 1, 0, -1);
    idle(20);
    send(8'hFF, 1, 0, 5 * SET + 20);
    idle(20);
    lit("rst_mid", pk(0, 0, 0, 0, 8'h00), M_ALL);
    send(8'h81, 1, 0, -1);
    idle(20);
    lit("after_rst", pk(1, 1, 0, 0, 8'h81), M_ALL);
    pop1();

    for (int j = 0; j < 8; j++) begin
      send(8'h10 + 8'(j), 1, 0, -1);
      idle(5);
    end
    send(8'h99, 1, 2, -1);
    idle(20);
    lit("coll", pk(1, 8, 0, 0, 8'h11), M_ALL);
    for (int j = 0; j < 8; j++) begin
      lit("coll_drain",
          pk(1, 8 - j, 0, 0, (j < 7) ? 8'h11 + 8'(j) : 8'h99),
          M_ALL);
      pop1();
    end
    lit("coll_empty", pk(0, 0, 0, 0, 8'h00), M_NODT);

    for (int j = 0; j < 40; j++) begin
      send(8'($urandom), $urandom_range(7) != 0, 1, -1);
      idle($urandom_range(30, 3));
    end
    data_out_ready = 1'b1;
    idle(12);
    data_out_ready = 1'b0;
    clr();
    lit("rand_end", pk(0, 0, 0, 0, 8'h00), M_NODT);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
